// File: rtl/pmp_cfg_writer_pkg.sv
// pmp_cfg_writer_pkg: shared PMP types (address mode, write error, per-entry config, writer FSM states)
package pmp_cfg_writer_pkg;
    localparam int DEF_PLEN       = 56;
    localparam int DEF_PMP_LEN    = 54;
    localparam int DEF_NR_ENTRIES = 16;
    typedef enum logic [1:0] {
        PMP_OFF   = 2'd0,
        PMP_TOR   = 2'd1,
        PMP_NA4   = 2'd2,
        PMP_NAPOT = 2'd3
    } pmp_addr_mode_t;
    typedef enum logic [1:0] {
        PMP_ERR_OK     = 2'd0,
        PMP_ERR_LOCKED = 2'd1,
        PMP_ERR_ALIGN  = 2'd2,
        PMP_ERR_RANGE  = 2'd3
    } pmp_wr_err_e;
    typedef struct packed {
        pmp_addr_mode_t mode;
        logic [2:0]     perm;
        logic           lock;
    } pmp_cfg_t;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WR_PREV,
        ST_WR_ENTRY,
        ST_RESP
    } wr_state_e;
endpackage

// File: rtl/pmp_napot_encode.sv
// pmp_napot_encode: base/size_log2 -> NAPOT pmpaddr plus alignment and size legality
//   base_i     region base byte address
//   size_i     log2 of region size in bytes (legal 3..PLEN)
//   addr_o     pmpaddr encoding (base>>2 with size-3 trailing ones)
//   align_ok_o base is a multiple of the region size
//   range_ok_o size is within 3..PLEN
module pmp_napot_encode
    import pmp_cfg_writer_pkg::*;
#(
    parameter int PLEN    = DEF_PLEN,
    parameter int PMP_LEN = DEF_PMP_LEN
) (
    input  logic [PLEN-1:0]    base_i,
    input  logic [5:0]         size_i,
    output logic [PMP_LEN-1:0] addr_o,
    output logic               align_ok_o,
    output logic               range_ok_o
);
    logic [5:0]         w_shift;
    logic [PMP_LEN-1:0] w_ones;
    logic [PLEN-1:0]    w_amask;
    assign w_shift    = size_i - 6'd3;
    assign w_ones     = ~({PMP_LEN{1'b1}} << w_shift);
    // a shift of PLEN clears everything, so size==PLEN masks the whole base
    assign w_amask    = ~({PLEN{1'b1}} << size_i);
    assign addr_o     = base_i[PLEN-1:2] | w_ones;
    assign align_ok_o = (base_i & w_amask) == '0;
    assign range_ok_o = (size_i >= 6'd3) && (size_i <= 6'(PLEN));
endmodule

// File: rtl/pmp_cfg_writer.sv
// pmp_cfg_writer: encodes PMP region requests into pmpaddr/pmpcfg and holds the entry register file
//   clk_i/rst_i                      clock, synchronous active-high reset
//   req_*                            region request (valid/ready handshake, accepted only in IDLE)
//   rsp_valid_o/rsp_ready_i/rsp_err_o result, held until consumed
//   conf_addr_o/mode/perm/lock       registered per-entry PMP configuration
module pmp_cfg_writer
    import pmp_cfg_writer_pkg::*;
#(
    parameter int  PLEN       = DEF_PLEN,
    parameter int  PMP_LEN    = DEF_PMP_LEN,
    parameter int  NR_ENTRIES = DEF_NR_ENTRIES,
    localparam int IDXW       = $clog2(NR_ENTRIES)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [IDXW-1:0]     req_idx_i,
    input  pmp_addr_mode_t      req_mode_i,
    input  logic [PLEN-1:0]     req_base_i,
    input  logic [PLEN-1:0]     req_top_i,
    input  logic [5:0]          req_size_log2_i,
    input  logic [2:0]          req_perm_i,
    input  logic                req_lock_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output pmp_wr_err_e         rsp_err_o,
    output logic [PMP_LEN-1:0]  conf_addr_o [NR_ENTRIES],
    output pmp_addr_mode_t      conf_mode_o [NR_ENTRIES],
    output logic [2:0]          conf_perm_o [NR_ENTRIES],
    output logic [NR_ENTRIES-1:0] conf_lock_o
);
    wr_state_e          r_state, w_next;
    logic [IDXW-1:0]    r_idx;
    pmp_addr_mode_t     r_mode;
    logic [PLEN-1:0]    r_base, r_top;
    logic [5:0]         r_size;
    logic [2:0]         r_perm;
    logic               r_lock;
    pmp_wr_err_e        r_err, w_err;
    logic [PMP_LEN-1:0] r_addr [NR_ENTRIES];
    pmp_cfg_t           r_cfg  [NR_ENTRIES];
    logic [PMP_LEN-1:0] w_napot_addr, w_enc;
    logic               w_align_ok, w_range_ok;
    logic [IDXW-1:0]    w_prev, w_nidx;
    logic               w_tor_prev, w_lock_err, w_range_err, w_align_err;
    pmp_napot_encode #(.PLEN(PLEN), .PMP_LEN(PMP_LEN)) u_napot (
        .base_i     (r_base),
        .size_i     (r_size),
        .addr_o     (w_napot_addr),
        .align_ok_o (w_align_ok),
        .range_ok_o (w_range_ok)
    );
    assign w_prev      = r_idx - IDXW'(1);
    assign w_nidx      = r_idx + IDXW'(1);
    assign w_tor_prev  = (r_mode == PMP_TOR) && (r_idx != '0);
    // writing idx also moves the bottom of a TOR region at idx+1, so a locked TOR above protects idx
    assign w_lock_err  = r_cfg[r_idx].lock
                       | (w_tor_prev & r_cfg[w_prev].lock)
                       | ((r_idx != IDXW'(NR_ENTRIES - 1)) & r_cfg[w_nidx].lock & (r_cfg[w_nidx].mode == PMP_TOR));
    assign w_range_err = ((r_mode == PMP_NAPOT) && !w_range_ok)
                       | ((r_mode == PMP_TOR) && (r_idx == '0) && (r_base != '0));
    assign w_align_err = ((r_mode == PMP_NA4) && (r_base[1:0] != 2'b00))
                       | ((r_mode == PMP_NAPOT) && !w_align_ok)
                       | ((r_mode == PMP_TOR) && ((r_base[1:0] | r_top[1:0]) != 2'b00));
    assign w_err       = w_lock_err  ? PMP_ERR_LOCKED :
                         w_range_err ? PMP_ERR_RANGE  :
                         w_align_err ? PMP_ERR_ALIGN  : PMP_ERR_OK;
    assign w_enc       = (r_mode == PMP_TOR)   ? r_top[PLEN-1:2] :
                         (r_mode == PMP_NAPOT) ? w_napot_addr    : r_base[PLEN-1:2];
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     w_next = req_valid_i ? ST_CHECK : ST_IDLE;
            ST_CHECK:    w_next = (w_err != PMP_ERR_OK) ? ST_RESP :
                                  w_tor_prev ? ST_WR_PREV : ST_WR_ENTRY;
            ST_WR_PREV:  w_next = ST_WR_ENTRY;
            ST_WR_ENTRY: w_next = ST_RESP;
            ST_RESP:     w_next = rsp_ready_i ? ST_IDLE : ST_RESP;
            default:     w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_err   <= PMP_ERR_OK;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                r_addr[i] <= '0;
                r_cfg[i]  <= '0;
            end
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && req_valid_i) begin
                r_idx  <= req_idx_i;
                r_mode <= req_mode_i;
                r_base <= req_base_i;
                r_top  <= req_top_i;
                r_size <= req_size_log2_i;
                r_perm <= req_perm_i;
                r_lock <= req_lock_i;
            end
            if (r_state == ST_CHECK) r_err <= w_err;
            if (r_state == ST_WR_PREV) r_addr[w_prev] <= r_base[PLEN-1:2];
            if (r_state == ST_WR_ENTRY) begin
                if (r_mode != PMP_OFF) r_addr[r_idx] <= w_enc;
                r_cfg[r_idx] <= '{mode: r_mode, perm: r_perm, lock: r_cfg[r_idx].lock | r_lock};
            end
        end
    end
    assign req_ready_o = r_state == ST_IDLE;
    assign rsp_valid_o = r_state == ST_RESP;
    assign rsp_err_o   = r_err;
    always_comb begin
        conf_lock_o = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            conf_addr_o[i] = r_addr[i];
            conf_mode_o[i] = r_cfg[i].mode;
            conf_perm_o[i] = r_cfg[i].perm;
            conf_lock_o[i] = r_cfg[i].lock;
        end
    end
endmodule

// File: tb/tb_pmp_cfg_writer.sv
// tb_pmp_cfg_writer: directed vectors with a response scoreboard for pmp_cfg_writer
module tb_pmp_cfg_writer;
    import pmp_cfg_writer_pkg::*;
    localparam int PLEN = 56, PMP_LEN = 54, NR = 16, IDXW = 4;
    logic               clk = 1'b0, rst_i = 1'b1;
    logic               req_valid_i, req_ready_o, req_lock_i, rsp_valid_o, rsp_ready_i;
    logic [IDXW-1:0]    req_idx_i;
    pmp_addr_mode_t     req_mode_i;
    logic [PLEN-1:0]    req_base_i, req_top_i;
    logic [5:0]         req_size_log2_i;
    logic [2:0]         req_perm_i;
    pmp_wr_err_e        rsp_err_o;
    logic [PMP_LEN-1:0] conf_addr_o [NR];
    pmp_addr_mode_t     conf_mode_o [NR];
    logic [2:0]         conf_perm_o [NR];
    logic [NR-1:0]      conf_lock_o;
    always #5 clk = ~clk;
    pmp_cfg_writer dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_idx_i       (req_idx_i),
        .req_mode_i      (req_mode_i),
        .req_base_i      (req_base_i),
        .req_top_i       (req_top_i),
        .req_size_log2_i (req_size_log2_i),
        .req_perm_i      (req_perm_i),
        .req_lock_i      (req_lock_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_err_o       (rsp_err_o),
        .conf_addr_o     (conf_addr_o),
        .conf_mode_o     (conf_mode_o),
        .conf_perm_o     (conf_perm_o),
        .conf_lock_o     (conf_lock_o)
    );
    typedef struct {
        pmp_wr_err_e err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t q[$];
    int   n_vec = 0, n_err = 0, cyc = 0, first = 0;
    bit   seen = 0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask
    always @(negedge clk) begin
        if (rst_i) seen = 0;
        else if (rsp_valid_o) begin
            if (!seen) begin
                seen  = 1;
                first = cyc;
            end
            if (rsp_ready_i) begin
                seen = 0;
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got err %0d with no request outstanding", rsp_err_o);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_err", rsp_err_o, e.err);
                    chk("rsp_latency", first - e.acc, e.lat);
                end
            end
        end
    end
    task automatic do_req(input logic [3:0] idx, input pmp_addr_mode_t mode, input logic [55:0] base,
                          input logic [55:0] top, input logic [5:0] sz, input logic [2:0] perm,
                          input logic lk, input pmp_wr_err_e err, input int lat, output int acc);
        bit done = 0;
        @(negedge clk);
        req_idx_i = idx; req_mode_i = mode; req_base_i = base; req_top_i = top;
        req_size_log2_i = sz; req_perm_i = perm; req_lock_i = lk; req_valid_i = 1'b1;
        acc = -1;
        for (int k = 0; k < 60 && !done; k++) begin
            if (req_ready_o) begin
                acc = cyc;
                q.push_back(exp_t'{err, lat, cyc});
                done = 1;
            end else @(negedge clk);
        end
        if (!done) fail("accept_timeout");
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask
    task automatic wait_idle();
        int k = 0;
        while ((q.size() != 0 || !req_ready_o) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) fail("idle_timeout");
        @(negedge clk);
    endtask
    initial begin
        int a, acc2, hold_pop, nz;
        bit got;
        req_valid_i = 0; req_idx_i = 0; req_mode_i = PMP_OFF; req_base_i = 0; req_top_i = 0;
        req_size_log2_i = 0; req_perm_i = 0; req_lock_i = 0; rsp_ready_i = 1;
        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        @(negedge clk);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_err", rsp_err_o, PMP_ERR_OK);
        chk("rst_addr3", conf_addr_o[3], 0);
        chk("rst_mode3", conf_mode_o[3], PMP_OFF);
        do_req(3, PMP_NAPOT, 56'h8000_0000, 0, 12, 3'b111, 0, PMP_ERR_OK, 3, a);
        wait_idle();
        chk("napot_addr3", conf_addr_o[3], 54'h2000_01FF);
        chk("napot_mode3", conf_mode_o[3], PMP_NAPOT);
        chk("napot_perm3", conf_perm_o[3], 3'b111);
        do_req(3, PMP_NAPOT, 56'h8000_0800, 0, 12, 3'b001, 0, PMP_ERR_ALIGN, 2, a);
        do_req(3, PMP_NAPOT, 56'h8000_0000, 0, 2, 3'b001, 0, PMP_ERR_RANGE, 2, a);
        do_req(1, PMP_NAPOT, 56'h0, 0, 57, 3'b001, 0, PMP_ERR_RANGE, 2, a);
        do_req(1, PMP_NAPOT, 56'h0, 0, 56, 3'b001, 0, PMP_ERR_OK, 3, a);
        wait_idle();
        chk("err_keeps_addr3", conf_addr_o[3], 54'h2000_01FF);
        chk("err_keeps_perm3", conf_perm_o[3], 3'b111);
        chk("napot_max_addr1", conf_addr_o[1], 54'h1F_FFFF_FFFF_FFFF);
        do_req(5, PMP_TOR, 56'h1000, 56'h2000, 0, 3'b011, 0, PMP_ERR_OK, 4, a);
        wait_idle();
        chk("tor_addr4", conf_addr_o[4], 54'h400);
        chk("tor_addr5", conf_addr_o[5], 54'h800);
        chk("tor_mode4", conf_mode_o[4], PMP_OFF);
        chk("tor_mode5", conf_mode_o[5], PMP_TOR);
        chk("tor_perm5", conf_perm_o[5], 3'b011);
        do_req(0, PMP_TOR, 56'h1000, 56'h2000, 0, 3'b001, 0, PMP_ERR_RANGE, 2, a);
        do_req(9, PMP_TOR, 56'h2000, 56'h1000, 0, 3'b001, 0, PMP_ERR_OK, 4, a);
        do_req(7, PMP_NA4, 56'h1002, 0, 0, 3'b001, 0, PMP_ERR_ALIGN, 2, a);
        do_req(7, PMP_NA4, 56'h1004, 0, 0, 3'b100, 0, PMP_ERR_OK, 3, a);
        do_req(12, PMP_TOR, 56'h1000, 56'h2001, 0, 3'b001, 0, PMP_ERR_ALIGN, 2, a);
        wait_idle();
        chk("tor_empty_addr8", conf_addr_o[8], 54'h800);
        chk("tor_empty_addr9", conf_addr_o[9], 54'h400);
        chk("na4_addr7", conf_addr_o[7], 54'h401);
        chk("na4_mode7", conf_mode_o[7], PMP_NA4);
        chk("tor_misalign_addr11", conf_addr_o[11], 0);
        chk("tor_misalign_mode12", conf_mode_o[12], PMP_OFF);
        do_req(2, PMP_NAPOT, 56'h40, 0, 3, 3'b001, 1, PMP_ERR_OK, 3, a);
        wait_idle();
        chk("lock2_set", conf_lock_o[2], 1);
        chk("lock2_addr", conf_addr_o[2], 54'h10);
        do_req(2, PMP_NA4, 56'h100, 0, 0, 3'b111, 0, PMP_ERR_LOCKED, 2, a);
        do_req(3, PMP_TOR, 56'h3000, 56'h4000, 0, 3'b111, 0, PMP_ERR_LOCKED, 2, a);
        wait_idle();
        chk("locked_addr2", conf_addr_o[2], 54'h10);
        chk("locked_mode3", conf_mode_o[3], PMP_NAPOT);
        do_req(6, PMP_NA4, 56'h200, 0, 0, 3'b001, 0, PMP_ERR_OK, 3, a);
        rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        q.delete();
        @(negedge clk);
        nz = 0;
        for (int i = 0; i < NR; i++) if (conf_mode_o[i] != PMP_OFF || conf_lock_o[i]) nz++;
        chk("rst_all_off", nz, 0);
        chk("rst_lock2", conf_lock_o[2], 0);
        chk("rst_abandon_addr6", conf_addr_o[6], 0);
        chk("rst_ready2", req_ready_o, 1);
        chk("rst_rsp_valid2", rsp_valid_o, 0);
        do_req(3, PMP_TOR, 56'h3000, 56'h4000, 0, 3'b101, 1, PMP_ERR_OK, 4, a);
        do_req(2, PMP_NA4, 56'h10, 0, 0, 3'b001, 0, PMP_ERR_LOCKED, 2, a);
        do_req(4, PMP_TOR, 56'h4000, 56'h5000, 0, 3'b001, 0, PMP_ERR_LOCKED, 2, a);
        do_req(4, PMP_NAPOT, 56'h4000, 0, 12, 3'b011, 0, PMP_ERR_OK, 3, a);
        do_req(0, PMP_TOR, 56'h0, 56'h100, 0, 3'b001, 1, PMP_ERR_OK, 3, a);
        do_req(15, PMP_NAPOT, 56'h8000, 0, 15, 3'b110, 0, PMP_ERR_OK, 3, a);
        wait_idle();
        chk("tor_lock_addr2", conf_addr_o[2], 54'hC00);
        chk("tor_lock_addr3", conf_addr_o[3], 54'h1000);
        chk("tor_lock_bit3", conf_lock_o[3], 1);
        chk("tor_lock_mode2", conf_mode_o[2], PMP_OFF);
        chk("above_tor_addr4", conf_addr_o[4], 54'h11FF);
        chk("tor0_addr0", conf_addr_o[0], 54'h40);
        chk("last_entry_addr15", conf_addr_o[15], 54'h2FFF);
        rsp_ready_i = 1'b0;
        do_req(10, PMP_NA4, 56'h102, 0, 0, 3'b101, 0, PMP_ERR_ALIGN, 2, a);
        hold_pop = -100;
        acc2 = -1;
        fork
            do_req(11, PMP_NAPOT, 56'h1_0000, 0, 16, 3'b111, 0, PMP_ERR_OK, 3, acc2);
            begin
                got = 0;
                for (int k = 0; k < 10 && !got; k++) begin
                    if (rsp_valid_o) got = 1;
                    else @(negedge clk);
                end
                if (!got) fail("hold_rsp_timeout");
                repeat (5) begin
                    chk("hold_valid", rsp_valid_o, 1);
                    chk("hold_err", rsp_err_o, PMP_ERR_ALIGN);
                    chk("hold_ready", req_ready_o, 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 rsp_ready_i = 1'b1;
                @(negedge clk);
                hold_pop = cyc;
            end
        join
        wait_idle();
        chk("held_req_accept_cycle", acc2, hold_pop + 1);
        chk("held_req_addr11", conf_addr_o[11], 54'h5FFF);
        chk("hold_err_addr10", conf_addr_o[10], 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
